rom_rd_stream: RTL and testbench

Read initiator for the single-port ROM (rom_sp).
- Accepts a command of start address plus word count.
- Drives the ROM read port (rd_en/rd_addr) and compensates for the ROM's 1+REG_OUT cycle read latency.
- Presents the words as a valid/ready stream with a last marker.
- An internal output FIFO absorbs downstream backpressure without losing in-flight ROM data.

---
 rtl/rom_rd_stream.sv | 179 +++++++++++++++++
 tb/tb_rom_rd_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_stream.sv
// Read initiator for the single-port ROM: turns an {address, length} command into
// ROM reads and presents the returned words as a valid/ready stream with a last marker.
module rom_rd_stream #(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned REG_OUT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [$clog2(DEPTH)-1:0] cmd_addr_i,
  input  logic [$clog2(DEPTH):0]   cmd_len_i,
  output logic                     rom_rd_en_o,
  output logic [$clog2(DEPTH)-1:0] rom_rd_addr_o,
  input  logic [D_WIDTH-1:0]       rom_rd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [D_WIDTH-1:0]       out_data_o,
  output logic                     out_last_o,
  output logic                     busy_o
);

  localparam int unsigned A   = $clog2(DEPTH);
  localparam int unsigned LAT = 1 + REG_OUT;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [A-1:0]  ADDR_MAX = A'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   FIFO_LIM = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [A:0]    LEN_ONE  = (A + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [A-1:0]         cur_addr;
  logic [A:0]           remaining;
  logic                 cmd_fire;
  logic                 issue;
  logic [A-1:0]         issue_addr;
  logic [A:0]           issue_rem;
  logic                 issue_last;
  logic                 rd_last_q;
  logic [LAT-1:0]       vld_sr;
  logic [LAT-1:0]       last_sr;
  logic [CW-1:0]        inflight_cnt;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [D_WIDTH-1:0]   data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic                 push;
  logic                 pop;
  logic [CW:0]          reserved;
  logic                 room;
  logic                 drain_done;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  assign push        = vld_sr[LAT-1];
  assign out_valid_o = (fifo_count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? data_mem[rd_ptr] : '0;
  assign out_last_o  = out_valid_o && last_mem[rd_ptr];

  // Every issued read owns a FIFO slot from issue until it is popped; a pop in
  // the same cycle frees its slot early so a full-rate stream never stalls.
  assign reserved   = {1'b0, fifo_count} + {1'b0, inflight_cnt} - (CW + 1)'(pop);
  assign room       = (reserved < FIFO_LIM);
  assign drain_done = (inflight_cnt == '0) && (fifo_count == CW'(pop));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The first read is issued straight from the accepting cycle.
  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = cur_addr;
    issue_rem  = remaining;
    case (state)
      IDLE: begin
        if (cmd_fire && (cmd_len_i != '0)) begin
          issue      = 1'b1;
          issue_addr = cmd_addr_i;
          issue_rem  = cmd_len_i;
          state_n    = (cmd_len_i == LEN_ONE) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if ((remaining != '0) && room) begin
          issue = 1'b1;
          if (remaining == LEN_ONE) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    issue_last = (issue_rem == LEN_ONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_addr      <= '0;
      remaining     <= '0;
      rom_rd_en_o   <= 1'b0;
      rom_rd_addr_o <= '0;
      rd_last_q     <= 1'b0;
      vld_sr        <= '0;
      last_sr       <= '0;
      inflight_cnt  <= '0;
    end else begin
      rom_rd_en_o <= issue;
      rd_last_q   <= issue && issue_last;
      if (issue) begin
        rom_rd_addr_o <= issue_addr;
        cur_addr      <= (issue_addr == ADDR_MAX) ? '0 : issue_addr + A'(1);
        remaining     <= issue_rem - LEN_ONE;
      end
      vld_sr[0]  <= rom_rd_en_o;
      last_sr[0] <= rd_last_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      inflight_cnt <= inflight_cnt + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= rom_rd_data_i;
      last_mem[wr_ptr] <= last_sr[LAT-1];
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && !pop && (fifo_count == FIFO_FULL)));

endmodule

// File: tb/tb_rom_rd_stream.sv
// Bench for rom_rd_stream: behavioural ROM with word i = i (REG_OUT=1), a table of
// command vectors plus hand-written zero-length and mid-operation reset sequences.
module tb_rom_rd_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          rom_rd_en;
  logic [AW-1:0] rom_rd_addr;
  logic [DW-1:0] rom_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  rom_rd_stream #(
    .D_WIDTH   (DW),
    .DEPTH     (65536),
    .REG_OUT   (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .rom_rd_en_o  (rom_rd_en),
    .rom_rd_addr_o(rom_rd_addr),
    .rom_rd_data_i(rom_rd_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .busy_o       (busy)
  );

  // ROM model: address registered on rd_en, then one output register stage.
  logic [DW-1:0] rom_s1;
  logic [DW-1:0] rom_s2;
  always_ff @(posedge clk) begin
    if (rom_rd_en) rom_s1 <= {16'h0000, rom_rd_addr};
    rom_s2 <= rom_s1;
  end
  assign rom_rd_data = rom_s2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [3:0]    rdy;
    int unsigned   lat;
    logic [DW-1:0] first_w;
    logic [DW-1:0] last_w;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, "_rd_en"},     {31'b0, rom_rd_en}, 32'd0);
    chk({tag, "_rd_addr"},   {16'b0, rom_rd_addr}, 32'd0);
    chk({tag, "_valid"},     {31'b0, out_valid}, 32'd0);
    chk({tag, "_data"},      out_data, 32'd0);
    chk({tag, "_last"},      {31'b0, out_last}, 32'd0);
    chk({tag, "_busy"},      {31'b0, busy}, 32'd0);
  endtask

  // Issues one command and follows it cycle by cycle until the last word is taken.
  task automatic run_cmd(input string tag, input logic [AW-1:0] addr, input logic [AW:0] len,
                         input logic [3:0] rdy, input int unsigned lat,
                         input logic [DW-1:0] exp_first, input logic [DW-1:0] exp_lastw);
    int unsigned   k, n, pulses, budget, len_u;
    logic          seen, prev_stall, prev_last, done;
    logic [DW-1:0] prev_data, first_w, last_w;
    logic [AW-1:0] ea;
    len_u      = int'(len);
    budget     = (rdy == 4'hF) ? len_u + 32 : 2 * len_u + 32;
    k = 0; n = 0; pulses = 0;
    seen = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; done = 1'b0;
    prev_data = '0; first_w = 32'hDEAD_BEEF; last_w = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; out_ready = rdy[0];
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      // A competing command held up while busy must be ignored.
      cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_len = 17'd3;
      out_ready = rdy[k % 4];
      if (rom_rd_en) pulses++;
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_stall_data"}, out_data, prev_data);
        chk({tag, "_stall_last"}, {31'b0, out_last}, {31'b0, prev_last});
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk({tag, "_first_valid_cycle"}, k, lat);
      end
      if (out_valid && out_ready) begin
        ea = addr + n[AW-1:0];
        chk({tag, "_data"}, out_data, {16'h0000, ea});
        chk({tag, "_last"}, {31'b0, out_last}, {31'b0, (n + 1 == len_u)});
        if (rdy == 4'hF) chk({tag, "_rate"}, k, lat + n);
        if (n == 0) first_w = out_data;
        last_w = out_data;
        n++;
        if (n == len_u) begin
          chk({tag, "_ready_busy"}, {31'b0, cmd_ready}, 32'd0);
          cmd_valid = 1'b0;
          done = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    cmd_valid = 1'b0;
    chk({tag, "_word_count"}, n, len_u);
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, "_ready_after"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, "_rd_pulses"}, pulses, len_u);
    chk({tag, "_first_word"}, first_w, exp_first);
    chk({tag, "_final_word"}, last_w, exp_lastw);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_quiet_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_quiet_rd_en"}, {31'b0, rom_rd_en}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k, n;
    logic any_rd, any_valid, any_busy;

    vecs[0] = '{16'h0010, 17'd8,     4'b1111, 4, 32'h0000_0010, 32'h0000_0017};
    vecs[1] = '{16'hFFFE, 17'd4,     4'b1111, 4, 32'h0000_FFFE, 32'h0000_0001};
    vecs[2] = '{16'h0000, 17'd16,    4'b1001, 4, 32'h0000_0000, 32'h0000_000F};
    vecs[3] = '{16'h0000, 17'd65536, 4'b1111, 4, 32'h0000_0000, 32'h0000_FFFF};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_cmd($sformatf("v%0d", i), vecs[i].addr, vecs[i].len, vecs[i].rdy,
              vecs[i].lat, vecs[i].first_w, vecs[i].last_w);
    end

    // Zero-length command is accepted but produces nothing.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 16'h0007; cmd_len = 17'd0;
    any_rd = 1'b0; any_valid = 1'b0; any_busy = busy;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      any_rd    = any_rd | rom_rd_en;
      any_valid = any_valid | out_valid;
      any_busy  = any_busy | busy;
    end
    chk("zero_rd_en", {31'b0, any_rd}, 32'd0);
    chk("zero_valid", {31'b0, any_valid}, 32'd0);
    chk("zero_busy",  {31'b0, any_busy}, 32'd0);
    run_cmd("len1", 16'h0005, 17'd1, 4'b1111, 4, 32'h5, 32'h5);

    // Reset in the middle of a long command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 16'h0000; cmd_len = 17'd100; out_ready = 1'b1;
    k = 0; n = 0;
    while (n < 20 && k < 200) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k++;
      if (out_valid && out_ready) n++;
    end
    chk("mid_words_before_reset", n, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    run_cmd("after_rst", 16'h0000, 17'd2, 4'b1111, 4, 32'h0, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
